// File: rtl/core_stream_pkg.sv
// Shared stream definitions for the core's valid/ready datapaths.
//   XLEN           : datapath word width
//   DEMUX_PORT_IF  : select encoding for the instruction-fetch port (port 0)
//   DEMUX_PORT_LSU : select encoding for the load/writeback port (port 1)
package core_stream_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic DEMUX_PORT_IF  = 1'b0;
    localparam logic DEMUX_PORT_LSU = 1'b1;

endpackage : core_stream_pkg

// File: rtl/stream_slot.sv
// One-entry stream holding register with fill/drain handshake.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_fill     : load i_data this cycle (wins over a simultaneous drain)
//   i_data     : word to load
//   i_ready    : downstream consumer accepts the held word
//   o_valid    : slot holds a word
//   o_data     : held word; keeps its last value after draining
module stream_slot #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_fill,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Fill has priority: a full slot that drains and refills in one cycle stays valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_fill) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule : stream_slot

// File: rtl/demux1x2_stream.sv
// Registered 1-to-2 stream demultiplexer: steers each accepted word to port 0
// (instruction fetch) or port 1 (load/writeback) by the per-word select bit.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   s_valid/s_ready/s_data/s_sel: input stream; s_sel picks the destination
//   m0_valid/m0_ready/m0_data   : port 0 output stream (registered)
//   m1_valid/m1_ready/m1_data   : port 1 output stream (registered)
//   busy                        : either port holds a word
module demux1x2_stream
    import core_stream_pkg::*;
#(
    parameter int unsigned WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_sel,
    output logic             m0_valid,
    input  logic             m0_ready,
    output logic [WIDTH-1:0] m0_data,
    output logic             m1_valid,
    input  logic             m1_ready,
    output logic [WIDTH-1:0] m1_data,
    output logic             busy
);

    logic w_sel_lsu;
    logic w_accept;
    logic w_fill0;
    logic w_fill1;

    assign w_sel_lsu = (s_sel == DEMUX_PORT_LSU);

    // Ready looks only at the selected slot: no bypass around a stalled port.
    assign s_ready = w_sel_lsu ? (!m1_valid || m1_ready)
                               : (!m0_valid || m0_ready);

    // s_valid gates first so an unknown select while idle cannot reach state.
    assign w_accept = s_valid && s_ready;
    assign w_fill0  = w_accept && (s_sel == DEMUX_PORT_IF);
    assign w_fill1  = w_accept && w_sel_lsu;

    stream_slot #(.WIDTH(WIDTH)) u_slot0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_fill  (w_fill0),
        .i_data  (s_data),
        .i_ready (m0_ready),
        .o_valid (m0_valid),
        .o_data  (m0_data)
    );

    stream_slot #(.WIDTH(WIDTH)) u_slot1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_fill  (w_fill1),
        .i_data  (s_data),
        .i_ready (m1_ready),
        .o_valid (m1_valid),
        .o_data  (m1_data)
    );

    assign busy = m0_valid || m1_valid;

endmodule : demux1x2_stream

// File: tb/tb_demux1x2_stream.sv
// Self-checking bench for demux1x2_stream: directed scenarios with literal
// expectations, then randomized traffic against a queue-based reference model.
module tb_demux1x2_stream;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst_n;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_data;
    logic         s_sel;
    logic         m0_valid;
    logic         m0_ready;
    logic [W-1:0] m0_data;
    logic         m1_valid;
    logic         m1_ready;
    logic [W-1:0] m1_data;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    demux1x2_stream #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_sel    (s_sel),
        .m0_valid (m0_valid),
        .m0_ready (m0_ready),
        .m0_data  (m0_data),
        .m1_valid (m1_valid),
        .m1_ready (m1_ready),
        .m1_data  (m1_data),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    // Reference model: each port is a FIFO of words accepted but not yet drained;
    // a port's output data is simply the last word ever routed to it.
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic [W-1:0] last0;
    logic [W-1:0] last1;
    logic         pend;
    bit           model_en;

    function automatic logic model_ready(input logic sel);
        if (sel) return (q1.size() == 0) || m1_ready;
        else     return (q0.size() == 0) || m0_ready;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            last0 = '0;
            last1 = '0;
            pend  = 1'b0;
        end else begin
            logic acc;
            acc = s_valid && model_ready(s_sel);
            if (q0.size() != 0 && m0_ready) void'(q0.pop_front());
            if (q1.size() != 0 && m1_ready) void'(q1.pop_front());
            if (acc) begin
                if (s_sel) begin q1.push_back(s_data); last1 = s_data; end
                else       begin q0.push_back(s_data); last0 = s_data; end
            end
            pend = s_valid && !acc;
        end
    end

    // Compare process: every falling edge while enabled and out of reset.
    always @(negedge clk) begin
        if (model_en && rst_n) begin
            chk("m0_valid", W'(m0_valid), W'(q0.size() != 0));
            chk("m1_valid", W'(m1_valid), W'(q1.size() != 0));
            chk("m0_data",  m0_data, last0);
            chk("m1_data",  m1_data, last1);
            chk("busy",     W'(busy), W'((q0.size() != 0) || (q1.size() != 0)));
            chk("s_ready",  W'(s_ready), W'(model_ready(s_sel)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic sel, input logic [W-1:0] d);
        s_valid = v;
        s_sel   = sel;
        s_data  = d;
    endtask

    initial begin
        model_en = 1'b0;
        rst_n    = 1'b0;
        drive(1'b0, 1'b0, '0);
        m0_ready = 1'b1;
        m1_ready = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        model_en = 1'b1;

        // Reset, then idle
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_m0_valid", W'(m0_valid), '0);
            chk("idle_m1_valid", W'(m1_valid), '0);
            chk("idle_busy", W'(busy), '0);
            chk("idle_m0_data", m0_data, '0);
            s_sel = 1'b0; #1;
            chk("idle_rdy_sel0", W'(s_ready), W'(1));
            s_sel = 1'b1; #1;
            chk("idle_rdy_sel1", W'(s_ready), W'(1));
            s_sel = 1'b0;
            tick();
        end

        // Single route to each port
        drive(1'b1, 1'b0, 32'hDEADBEEF);
        tick();
        drive(1'b1, 1'b1, 32'h12345678);
        @(negedge clk);
        chk("route_m0_valid", W'(m0_valid), W'(1));
        chk("route_m0_data", m0_data, 32'hDEADBEEF);
        chk("route_m1_idle", W'(m1_valid), '0);
        tick();
        drive(1'b0, 1'b0, '0);
        @(negedge clk);
        chk("route_m0_once", W'(m0_valid), '0);
        chk("route_m1_valid", W'(m1_valid), W'(1));
        chk("route_m1_data", m1_data, 32'h12345678);
        tick();
        @(negedge clk);
        chk("route_m1_once", W'(m1_valid), '0);

        // Back-to-back streaming to port 1
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, W'(i));
            @(negedge clk);
            chk("b2b_s_ready", W'(s_ready), W'(1));
            chk("b2b_m0_valid", W'(m0_valid), '0);
            if (i > 0) begin
                chk("b2b_m1_valid", W'(m1_valid), W'(1));
                chk("b2b_m1_data", m1_data, W'(i - 1));
            end
            tick();
        end
        drive(1'b0, 1'b0, '0);
        @(negedge clk);
        chk("b2b_m1_last", m1_data, W'(7));
        tick();

        // Backpressure and stall on port 0
        m0_ready = 1'b0;
        drive(1'b1, 1'b0, 32'hA);
        tick();
        drive(1'b1, 1'b0, 32'hB);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", W'(m0_valid), W'(1));
            chk("bp_hold_data", m0_data, 32'hA);
            chk("bp_stall", W'(s_ready), '0);
            tick();
        end
        m0_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_rdy", W'(s_ready), W'(1));
        chk("bp_release_data", m0_data, 32'hA);
        tick();
        drive(1'b0, 1'b0, '0);
        @(negedge clk);
        chk("bp_next_valid", W'(m0_valid), W'(1));
        chk("bp_next_data", m0_data, 32'hB);
        tick();

        // Cross-port independence
        m0_ready = 1'b0;
        drive(1'b1, 1'b0, 32'h55);
        tick();
        drive(1'b1, 1'b1, 32'h66);
        @(negedge clk);
        chk("xp_rdy", W'(s_ready), W'(1));
        chk("xp_busy0", W'(busy), W'(1));
        tick();
        drive(1'b0, 1'b0, '0);
        @(negedge clk);
        chk("xp_m1_valid", W'(m1_valid), W'(1));
        chk("xp_m1_data", m1_data, 32'h66);
        chk("xp_m0_data", m0_data, 32'h55);
        chk("xp_busy1", W'(busy), W'(1));
        tick();
        @(negedge clk);
        chk("xp_m1_drained", W'(m1_valid), '0);
        chk("xp_m0_still", m0_data, 32'h55);
        chk("xp_busy2", W'(busy), W'(1));
        m0_ready = 1'b1;
        tick();

        // Async reset mid-traffic
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        drive(1'b1, 1'b0, 32'h11);
        tick();
        drive(1'b1, 1'b1, 32'h22);
        tick();
        drive(1'b0, 1'b0, '0);
        @(negedge clk);
        chk("ar_full0", W'(m0_valid), W'(1));
        chk("ar_full1", W'(m1_valid), W'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_m0_valid", W'(m0_valid), '0);
        chk("ar_m1_valid", W'(m1_valid), '0);
        chk("ar_busy", W'(busy), '0);
        tick();
        rst_n = 1'b1;
        m0_ready = 1'b1;
        m1_ready = 1'b1;
        drive(1'b1, 1'b1, 32'h77);
        tick();
        drive(1'b0, 1'b0, '0);
        @(negedge clk);
        chk("ar_post_valid", W'(m1_valid), W'(1));
        chk("ar_post_data", m1_data, 32'h77);
        chk("ar_post_m0", W'(m0_valid), '0);
        tick();

        // Randomized traffic; producer holds a stalled word stable
        for (int i = 0; i < 3000; i++) begin
            m0_ready = ($urandom_range(0, 3) != 0);
            m1_ready = ($urandom_range(0, 2) != 0);
            if (!pend) begin
                s_valid = ($urandom_range(0, 9) < 6);
                s_sel   = 1'($urandom_range(0, 1));
                s_data  = $urandom;
            end
            tick();
        end
        drive(1'b0, 1'b0, '0);
        m0_ready = 1'b1;
        m1_ready = 1'b1;
        repeat (3) tick();

        model_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_demux1x2_stream
